// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Brief    : Shared types and constants for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_arb_state_t;

    localparam int CH_FETCH  = 0;
    localparam int CH_LSU    = 1;
    localparam int CH_LOADER = 2;

    localparam int DEFAULT_DATA_W = 32;
    localparam int BYTE_LANES     = DEFAULT_DATA_W / 8;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational rotating-priority pick; one-hot grant plus index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CH = 3,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any_grant
);

    int w_cand;

    // Scanning starts one past the previous winner, which therefore ranks last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_cand    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = (int'(last_grant) + k) % NUM_CH;
            if (!any_grant && req[w_cand]) begin
                any_grant      = 1'b1;
                grant[w_cand]  = 1'b1;
                grant_idx      = IDX_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one single-port,
//            fixed-latency memory; exactly one transaction in flight.
//            Define MEM_ARB_ALIGN_CHECK_EN to reject misaligned requests.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                         clock,
    input  logic                         clear_n,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_write,
    input  logic [NUM_CH*ADDR_W-1:0]     req_addr,
    input  logic [NUM_CH*DATA_W-1:0]     req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0]   req_wmask,
    output logic [NUM_CH-1:0]            rsp_valid,
    output logic                         rsp_error,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [DATA_W/8-1:0]          mem_wmask,
    input  logic [DATA_W-1:0]            mem_rdata
);

    localparam int LANES = byte_lanes(DATA_W);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    mem_arb_state_t     r_state;
    mem_arb_state_t     w_next_state;

    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   r_ch;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [LANES-1:0]   r_wmask;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_rdata;

    logic [NUM_CH-1:0]  w_req;
    logic [NUM_CH-1:0]  w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_any;
    logic               w_accept;
    logic               w_misaligned;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [LANES-1:0]   w_sel_wmask;

    // Holding off grants during reset keeps a requester from seeing a
    // handshake that the reset is about to discard.
    assign w_req = req_valid & {NUM_CH{clear_n}};

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .any_grant  (w_any)
    );

    assign w_accept    = (r_state == IDLE) && w_any;
    assign w_sel_addr  = req_addr [int'(w_grant_idx)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wdata[int'(w_grant_idx)*DATA_W +: DATA_W];
    assign w_sel_wmask = req_wmask[int'(w_grant_idx)*LANES  +: LANES];

`ifdef MEM_ARB_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LANES - 1);
    logic r_error;

    assign w_misaligned = |(w_sel_addr & OFFSET_MASK);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= w_misaligned;
        end
    end
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_misaligned ? RESP : ISSUE;
                end
            end
            ISSUE:   w_next_state = WAIT;
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_last_grant <= IDX_W'(NUM_CH - 1);
            r_ch         <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_cnt        <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_grant_idx;
                        r_ch         <= w_grant_idx;
                        r_write      <= req_write[w_grant_idx];
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_wmask      <= w_sel_wmask;
                        r_rdata      <= '0;
                    end
                end
                ISSUE: r_cnt <= CNT_LOAD;
                WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_write) begin
                            r_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_error = 1'b0;
        rsp_rdata = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        case (r_state)
            IDLE: req_ready = w_grant;
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = r_write;
                mem_addr  = r_addr & WORD_MASK;
                mem_wdata = r_wdata;
                mem_wmask = r_wmask;
            end
            RESP: begin
                rsp_valid = NUM_CH'(1) << r_ch;
                rsp_rdata = r_rdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
                rsp_error = r_error;
`endif
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed bench for mem_arbiter at MEM_LATENCY 1 and 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance with MEM_LATENCY = 1
    logic        clear_n;
    logic [2:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [95:0] req_addr, req_wdata;
    logic [11:0] req_wmask;
    logic        rsp_error, mem_en, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    // Instance with MEM_LATENCY = 4
    logic        clear_n_l4;
    logic [2:0]  req_valid_l4, req_ready_l4, req_write_l4, rsp_valid_l4;
    logic [95:0] req_addr_l4, req_wdata_l4;
    logic [11:0] req_wmask_l4;
    logic        rsp_error_l4, mem_en_l4, mem_we_l4;
    logic [31:0] rsp_rdata_l4, mem_addr_l4, mem_wdata_l4, mem_rdata_l4;
    logic [3:0]  mem_wmask_l4;

    mem_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut (
        .clock(clock), .clear_n(clear_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) u_dut_l4 (
        .clock(clock), .clear_n(clear_n_l4),
        .req_valid(req_valid_l4), .req_ready(req_ready_l4), .req_write(req_write_l4),
        .req_addr(req_addr_l4), .req_wdata(req_wdata_l4), .req_wmask(req_wmask_l4),
        .rsp_valid(rsp_valid_l4), .rsp_error(rsp_error_l4), .rsp_rdata(rsp_rdata_l4),
        .mem_en(mem_en_l4), .mem_we(mem_we_l4), .mem_addr(mem_addr_l4),
        .mem_wdata(mem_wdata_l4), .mem_wmask(mem_wmask_l4), .mem_rdata(mem_rdata_l4)
    );

    // Latency-1 memory: data valid the cycle after mem_en.
    logic [31:0] mem1 [0:255];
    logic        mem1_init = 1'b0;
    always @(posedge clock) begin
        if (!mem1_init) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'h0;
            mem1[0]   <= 32'h0123_4567;
            mem1[2]   <= 32'hAABB_CCDD;
            mem1[64]  <= 32'hDEAD_BEEF;
            mem1_init <= 1'b1;
        end else if (mem_en) begin
            mem_rdata <= mem1[mem_addr[9:2]];
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wmask[b]) mem1[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Latency-4 read-only memory built as a 4-deep pipe.
    logic [31:0] mem4 [0:255];
    logic [31:0] pipe4 [0:3];
    logic        mem4_init = 1'b0;
    always @(posedge clock) begin
        if (!mem4_init) begin
            for (int i = 0; i < 256; i++) mem4[i] <= 32'h0;
            mem4[4]   <= 32'hCAFE_F00D;
            mem4_init <= 1'b1;
        end
        pipe4[0] <= mem_en_l4 ? mem4[mem_addr_l4[9:2]] : 32'h0;
        for (int k = 1; k < 4; k++) pipe4[k] <= pipe4[k-1];
    end
    assign mem_rdata_l4 = pipe4[3];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated transaction on the latency-1 instance, DUT idle on entry.
    task automatic txn(input string tag, input int ch, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask, input logic [31:0] exp_rdata);
        @(negedge clock);
        req_valid              = 3'b001 << ch;
        req_write[ch]          = wr;
        req_addr[ch*32 +: 32]  = addr;
        req_wdata[ch*32 +: 32] = wdata;
        req_wmask[ch*4 +: 4]   = wmask;
        #1 check({tag, "_ready"}, 32'(req_ready), 32'(3'b001 << ch));
        @(negedge clock);
        req_valid = 3'b000;
        #1 check({tag, "_mem_en"}, 32'(mem_en), 32'd1);
        check({tag, "_mem_we"}, 32'(mem_we), 32'(wr));
        check({tag, "_mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        if (wr) begin
            check({tag, "_mem_wdata"}, mem_wdata, wdata);
            check({tag, "_mem_wmask"}, 32'(mem_wmask), 32'(wmask));
        end
        @(negedge clock);
        #1 check({tag, "_en_once"}, 32'(mem_en), 32'd0);
        check({tag, "_rsp_early"}, 32'(rsp_valid), 32'd0);
        @(negedge clock);
        #1 check({tag, "_rsp"}, 32'(rsp_valid), 32'(3'b001 << ch));
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(rsp_error), 32'd0);
        @(negedge clock);
        #1 check({tag, "_rsp_end"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    logic [31:0] cont_rdata [0:2];
    initial begin
        cont_rdata[0] = 32'hDEAD_BEEF;
        cont_rdata[1] = 32'hAABB_3344;
        cont_rdata[2] = 32'h0123_4567;

        clear_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        clear_n_l4 = 1'b0; req_valid_l4 = '0; req_write_l4 = '0; req_addr_l4 = '0;
        req_wdata_l4 = '0; req_wmask_l4 = '0;

        // Reset state, with requests present to show ready stays low.
        @(negedge clock);
        req_valid = 3'b111; req_valid_l4 = 3'b111;
        #1 check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_ready_l4", 32'(req_ready_l4), 32'd0);
        check("rst_rsp", 32'(rsp_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_error), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        @(negedge clock);
        req_valid = '0; req_valid_l4 = '0;
        clear_n = 1'b1; clear_n_l4 = 1'b1;

        txn("rd",   CH_LSU,    1'b0, 32'h100, 32'h0,         4'b0000, 32'hDEAD_BEEF);
        txn("wr",   CH_LOADER, 1'b1, 32'h008, 32'h1122_3344, 4'b0011, 32'h0);
        txn("rdbk", CH_FETCH,  1'b0, 32'h008, 32'h0,         4'b0000, 32'hAABB_3344);

        // Misaligned read from ch0.
        @(negedge clock);
        req_valid = 3'b001; req_write[0] = 1'b0; req_addr[31:0] = 32'h102;
        #1 check("mis_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 3'b000;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        #1 check("mis_mem_en", 32'(mem_en), 32'd0);
        check("mis_rsp", 32'(rsp_valid), 32'd1);
        check("mis_err", 32'(rsp_error), 32'd1);
        check("mis_rdata", rsp_rdata, 32'd0);
        @(negedge clock);
        #1 check("mis_end_rsp", 32'(rsp_valid), 32'd0);
        check("mis_end_en", 32'(mem_en), 32'd0);
`else
        #1 check("mis_mem_en", 32'(mem_en), 32'd1);
        check("mis_addr", mem_addr, 32'h100);
        @(negedge clock);
        @(negedge clock);
        #1 check("mis_rsp", 32'(rsp_valid), 32'd1);
        check("mis_err", 32'(rsp_error), 32'd0);
        check("mis_rdata", rsp_rdata, 32'hDEAD_BEEF);
        @(negedge clock);
        #1 check("mis_end_rsp", 32'(rsp_valid), 32'd0);
`endif

        // Contention from reset: strict rotation 0,1,2,0 every 4 cycles.
        @(negedge clock);
        clear_n = 1'b0;
        req_valid = 3'b111; req_write = 3'b000;
        req_addr = {32'h0000_0000, 32'h0000_0008, 32'h0000_0100};
        #1 check("cont_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            #1;
            check($sformatf("cont_ready_%0d", i), 32'(req_ready),
                  (i % 4 == 0) ? 32'(3'b001 << ((i / 4) % 3)) : 32'd0);
            check($sformatf("cont_rsp_%0d", i), 32'(rsp_valid),
                  (i % 4 == 3) ? 32'(3'b001 << ((i / 4) % 3)) : 32'd0);
            if (i % 4 == 3) check($sformatf("cont_rdata_%0d", i), rsp_rdata, cont_rdata[(i / 4) % 3]);
            @(negedge clock);
        end
        req_valid = 3'b000;
        repeat (3) @(negedge clock);

        // Latency 4: back-to-back ch0 reads, accepts 7 apart, response at T+6.
        req_valid_l4 = 3'b001; req_write_l4 = 3'b000; req_addr_l4[31:0] = 32'h10;
        for (int i = 0; i < 15; i++) begin
            #1;
            check($sformatf("lat_ready_%0d", i), 32'(req_ready_l4), (i % 7 == 0) ? 32'd1 : 32'd0);
            check($sformatf("lat_rsp_%0d", i), 32'(rsp_valid_l4), (i % 7 == 6) ? 32'd1 : 32'd0);
            check($sformatf("lat_en_%0d", i), 32'(mem_en_l4), (i % 7 == 1) ? 32'd1 : 32'd0);
            if (i % 7 == 1) check($sformatf("lat_we_%0d", i), 32'(mem_we_l4), 32'd0);
            if (i % 7 == 6) check($sformatf("lat_rdata_%0d", i), rsp_rdata_l4, 32'hCAFE_F00D);
            @(negedge clock);
        end
        req_valid_l4 = 3'b000;
        repeat (6) @(negedge clock);

        // Reset while ch1's read sits in WAIT: no response, ch0 first afterwards.
        req_valid_l4 = 3'b010; req_addr_l4[63:32] = 32'h10;
        #1 check("rstw_ready", 32'(req_ready_l4), 32'd2);
        @(negedge clock);
        req_valid_l4 = 3'b000;
        @(negedge clock);
        @(negedge clock);
        clear_n_l4 = 1'b0;
        @(negedge clock);
        clear_n_l4 = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #1;
            check($sformatf("rstw_rsp_%0d", j), 32'(rsp_valid_l4), 32'd0);
            check($sformatf("rstw_en_%0d", j), 32'(mem_en_l4), 32'd0);
            @(negedge clock);
        end
        req_valid_l4 = 3'b111;
        #1 check("rstw_next_grant", 32'(req_ready_l4), 32'd1);
        @(negedge clock);
        req_valid_l4 = 3'b000;
        repeat (7) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
